// File: rtl/sd_pkg.sv
// Shared constants and types for the SD SPI-mode card responder and its CRC7 helper.
package sd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RECV,
    ST_EXEC,
    ST_GAP,
    ST_RESP
  } sd_state_e;

  localparam logic [5:0] CMD0  = 6'd0;
  localparam logic [5:0] CMD8  = 6'd8;
  localparam logic [5:0] CMD41 = 6'd41;
  localparam logic [5:0] CMD55 = 6'd55;
  localparam logic [5:0] CMD58 = 6'd58;

  localparam int R1_IDLE    = 0;
  localparam int R1_ILLEGAL = 2;
  localparam int R1_CRC_ERR = 3;

  localparam logic [6:0] CRC7_POLY = 7'h09;
  localparam int         FRAME_LEN = 48;

  // One serial step of CRC7, MSB-first.
  function automatic logic [6:0] crc7_next(input logic [6:0] crc, input logic din);
    logic fb;
    fb = din ^ crc[6];
    return {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
  endfunction

endpackage

// File: rtl/sd_crc7.sv
// Serial CRC7 (x^7+x^3+1) accumulator; clr has priority over en.
module sd_crc7
  import sd_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       en,
  input  logic       din,
  output logic [6:0] crc
);

  always_ff @(posedge clk) begin
    if (!rst_n)   crc <= '0;
    else if (clr) crc <= '0;
    else if (en)  crc <= crc7_next(crc, din);
  end

endmodule

// File: rtl/sd_spi_card_responder.sv
// Card-side SD SPI-mode responder: deframes 48-bit commands, checks CRC7 and
// answers R1/R3/R7 through the idle -> ready initialisation sequence.
module sd_spi_card_responder
  import sd_pkg::*;
#(
  parameter int          NCR             = 1,
  parameter int          INIT_BUSY_COUNT = 3,
  parameter logic [31:0] OCR             = 32'hC0FF_8000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        SD_CLK,
  input  logic        SD_IN,
  output logic        SD_OUT,
  output logic        cmd_valid,
  output logic [5:0]  cmd_index,
  output logic [31:0] cmd_arg,
  output logic        crc_err,
  output logic        card_idle
);

  localparam logic [6:0] GAP_LAST = 7'(NCR * 8 - 1);
  localparam logic [7:0] BUSY_MAX = 8'(INIT_BUSY_COUNT);
  localparam logic [5:0] LAST_BIT = 6'(FRAME_LEN - 1);

  sd_state_e   state, state_n;
  logic [2:0]  sck_pipe;
  logic [1:0]  din_pipe;
  logic        sck_rise, sck_fall, din;
  logic [45:0] shreg;
  logic [46:0] frame_nxt;
  logic [5:0]  bit_cnt;
  logic [6:0]  gap_cnt;
  logic [39:0] resp_sr;
  logic [5:0]  resp_len;
  logic        sd_out_q;
  logic        idle_q, app_cmd;
  logic [7:0]  acmd_cnt;
  logic [6:0]  crc;
  logic        crc_en;

  logic [7:0]  r1_x, cnt_inc, cnt_x;
  logic [31:0] body_x;
  logic [5:0]  len_x;
  logic        idle_x, app_x;

  // SD_IN travels through the same depth as SD_CLK[1] so data and strobe stay aligned.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sck_pipe <= '0;
      din_pipe <= '0;
    end else begin
      sck_pipe <= {sck_pipe[1:0], SD_CLK};
      din_pipe <= {din_pipe[0], SD_IN};
    end
  end

  assign sck_rise  = sck_pipe[1] & ~sck_pipe[2];
  assign sck_fall  = ~sck_pipe[1] & sck_pipe[2];
  assign din       = din_pipe[1];
  assign frame_nxt = {shreg, din};

  assign SD_OUT    = sd_out_q;
  assign card_idle = idle_q;
  assign cmd_valid = (state == ST_EXEC);

  // Bits 46..8 feed the CRC; the leading start bit is zero and leaves it unchanged.
  assign crc_en = sck_rise && (state == ST_RECV) && (bit_cnt < 6'd40);

  sd_crc7 u_crc7 (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (state == ST_IDLE),
    .en    (crc_en),
    .din   (din),
    .crc   (crc)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE: if (sck_rise && !din) state_n = ST_RECV;
      ST_RECV: if (sck_rise && bit_cnt == LAST_BIT)
                 state_n = frame_nxt[46] ? ST_EXEC : ST_IDLE;
      ST_EXEC: state_n = ST_GAP;
      ST_GAP:  if (sck_fall && gap_cnt == GAP_LAST) state_n = ST_RESP;
      ST_RESP: if (sck_fall && bit_cnt == resp_len) state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  assign cnt_inc = (acmd_cnt == 8'hFF) ? acmd_cnt : acmd_cnt + 8'd1;

  // Command execution: response contents and card-state updates applied in EXEC.
  always_comb begin
    idle_x = idle_q;
    app_x  = 1'b0;
    cnt_x  = acmd_cnt;
    len_x  = 6'd8;
    r1_x   = 8'h00;
    body_x = 32'h0;
    if (crc_err) begin
      r1_x[R1_CRC_ERR] = 1'b1;
    end else begin
      case (cmd_index)
        CMD0: begin
          idle_x = 1'b1;
          cnt_x  = 8'h00;
        end
        CMD8: begin
          len_x  = 6'd40;
          body_x = {16'h0, 4'h0, cmd_arg[11:0]};
        end
        CMD55: app_x = 1'b1;
        CMD41: begin
          if (app_cmd) begin
            cnt_x = cnt_inc;
            if (cnt_inc > BUSY_MAX) idle_x = 1'b0;
          end else begin
            r1_x[R1_ILLEGAL] = 1'b1;
          end
        end
        CMD58: begin
          len_x  = 6'd40;
          body_x = OCR;
        end
        default: r1_x[R1_ILLEGAL] = 1'b1;
      endcase
    end
    r1_x[R1_IDLE] = idle_x;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shreg     <= '0;
      bit_cnt   <= '0;
      gap_cnt   <= '0;
      resp_sr   <= '0;
      resp_len  <= '0;
      sd_out_q  <= 1'b1;
      idle_q    <= 1'b1;
      app_cmd   <= 1'b0;
      acmd_cnt  <= '0;
      cmd_index <= '0;
      cmd_arg   <= '0;
      crc_err   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          sd_out_q <= 1'b1;
          if (sck_rise && !din) begin
            shreg   <= '0;
            bit_cnt <= 6'd1;
          end
        end
        ST_RECV: begin
          if (sck_rise) begin
            shreg   <= frame_nxt[45:0];
            bit_cnt <= bit_cnt + 6'd1;
            // Latch on the end bit so the decode is ready while cmd_valid is high.
            if (bit_cnt == LAST_BIT && frame_nxt[46]) begin
              cmd_index <= frame_nxt[45:40];
              cmd_arg   <= frame_nxt[39:8];
              crc_err   <= (frame_nxt[45:40] == CMD0 || frame_nxt[45:40] == CMD8) &&
                           (crc != frame_nxt[7:1]);
            end
          end
        end
        ST_EXEC: begin
          resp_sr  <= {r1_x, body_x};
          resp_len <= len_x;
          idle_q   <= idle_x;
          app_cmd  <= app_x;
          acmd_cnt <= cnt_x;
          gap_cnt  <= '0;
          bit_cnt  <= '0;
        end
        ST_GAP: begin
          if (sck_fall) begin
            sd_out_q <= 1'b1;
            gap_cnt  <= gap_cnt + 7'd1;
          end
        end
        ST_RESP: begin
          if (sck_fall) begin
            if (bit_cnt == resp_len) begin
              sd_out_q <= 1'b1;
            end else begin
              sd_out_q <= resp_sr[39];
              resp_sr  <= {resp_sr[38:0], 1'b0};
              bit_cnt  <= bit_cnt + 6'd1;
            end
          end
        end
        default: sd_out_q <= 1'b1;
      endcase
    end
  end

endmodule

// File: doc/sd_spi_card_responder.md
# sd_spi_card_responder

Synthesizable card-side responder for the SD SPI-mode link driven by `SD_TOP`. It samples the host's `SD_CLK`/`SD_DATAIN` pins, deframes 48-bit command tokens and checks CRC7. It then returns R1/R3/R7 responses on the card-to-host data line, carrying the card through the idle → ready initialisation sequence (CMD0, CMD8, CMD55/ACMD41, CMD58). It serves as the synthesizable replacement for the behavioural `SD` card model and as a loopback target in the `tb` environment.

## Interface
Parameters:
- `NCR`, 1: number of all-ones bytes between the command end bit and the first response bit; legal range 1..8.
- `INIT_BUSY_COUNT`, 3: number of ACMD41 commands answered with R1=0x01 before the card reports ready (R1=0x00).
- `OCR`, 32'hC0FF_8000: OCR value returned by CMD58.

Ports (one clock; reset is synchronous and active-low):
- `clk`  in  1  system clock; must run at least 4× `SD_CLK`.
- `rst_n`  in  1  synchronous active-low reset.
- `SD_CLK`  in  1  host SPI clock, asynchronous to `clk`.
- `SD_IN`  in  1  host-to-card serial data (connects to the host's `SD_DATAIN`).
- `SD_OUT`  out  1  card-to-host serial data (connects to the host's `SD_DATAOUT`); idles high.
- `cmd_valid`  out  1  one-`clk` pulse when a complete command has been deframed.
- `cmd_index`  out  6  index of the last command; held until the next command.
- `cmd_arg`  out  32  argument of the last command; held until the next command.
- `crc_err`  out  1  set when the last command failed its CRC check; held until the next command.
- `card_idle`  out  1  mirrors R1 bit 0 (in-idle-state).

## Operation
- **Clock handling.** `SD_CLK` passes through a 2-flop synchroniser plus one history flop. `sck_rise` and `sck_fall` are single-`clk` strobes. SPI mode 0 applies: `SD_IN` is sampled on `sck_rise`, and `SD_OUT` updates on `sck_fall`.
- **FSM states:** IDLE, RECV, EXEC, GAP, RESP.
  - **IDLE.** On `sck_rise` with `SD_IN`=0, the card takes this as the start bit and moves to RECV with bit count 1.
  - **RECV.** Shifts bits into a 48-bit register. After the 48th bit it goes to EXEC. If bit 1 (the transmission bit) is not 1, the frame is discarded and the FSM returns to IDLE with no response.
  - **EXEC.** Lasts exactly one `clk`. In this state the card:
    - pulses `cmd_valid`;
    - latches `cmd_index`, `cmd_arg` and `crc_err`;
    - builds the response shift register and its length (8 or 40 bits);
    - moves to GAP.
  - **GAP.** Drives `SD_OUT`=1 for `NCR`×8 `sck_fall` edges, then moves to RESP.
  - **RESP.** On each `sck_fall`, drives the next bit, MSB first. After the last bit, the next `sck_fall` drives 1 and the FSM returns to IDLE.
- **Half-duplex.** `SD_IN` is ignored in EXEC, GAP and RESP. A start bit sent during a response is lost.
- **CRC.** CRC7 (polynomial x^7+x^3+1) is computed over bits 47..8. It is checked only for CMD0 and CMD8; other commands are not checked. On a mismatch, R1 bit 3 (CRC error) is set, the command is not executed, and the response is R1 only.
- **R1 format.** Bit 0 = idle; bit 2 = illegal command; bit 3 = CRC error; all other bits are 0.
- **Command responses:**
  - CMD0: sets idle, clears the ACMD41 counter. Response R1 = {idle}.
  - CMD8: R7 = R1, 8'h00, 8'h00, {4'h0, arg[11:8]}, arg[7:0].
  - CMD55: R1; sets the `app_cmd` flag.
  - ACMD41 (index 41 with `app_cmd` set): increments the counter. While the counter ≤ `INIT_BUSY_COUNT`, R1 = 0x01. After that, idle clears and R1 = 0x00.
  - CMD58: R3 = R1 followed by `OCR`.
  - Anything else, including CMD41 without a preceding CMD55: R1 with bit 2 set.
- **`app_cmd`.** Cleared in EXEC of every command other than CMD55.
- **Counter.** The ACMD41 counter saturates; it does not wrap.

## Timing
- **Reset values:**
  - `SD_OUT`=1, `cmd_valid`=0, `cmd_index`=0, `cmd_arg`=0, `crc_err`=0.
  - `card_idle`=1, `app_cmd`=0, ACMD41 counter=0, FSM in IDLE.
  - Synchroniser flops reset to 0.
- **Sampling latency.** A pin edge on `SD_CLK` is acted on 3 `clk` after it occurs.
- **Command-to-response latency.**
  - `cmd_valid` asserts 1 `clk` after the `sck_rise` that samples the end bit.
  - The first response bit appears on the (`NCR`×8+1)-th `sck_fall` after that.
- **Reset mid-operation.** The response is aborted and `SD_OUT` returns to 1 on the next `clk` edge. Any partial frame is discarded.
- **Simultaneous strobes.** `sck_rise` and `sck_fall` are mutually exclusive by construction.

## Structure
- **Package `sd_pkg`:**
  - FSM state enum;
  - command-index constants (CMD0, CMD8, CMD41, CMD55, CMD58);
  - R1 bit positions;
  - CRC7 polynomial constant;
  - frame length (48).
- **Sub-module `sd_crc7`:** serial CRC7 with `clk`, `rst_n`, `clr`, `en` and `din` inputs and a `crc[6:0]` output. It is advanced on each `sck_rise` in RECV for bits 47..8. The host side reuses it.

## Test plan
1. **Reset.** Hold `rst_n`=0 for 4 `clk` → `SD_OUT`=1, `card_idle`=1, `cmd_valid`=0.
2. **CMD0.** Send 40 00 00 00 00 95 → `cmd_valid` pulse with `cmd_index`=0. After 8 high bits, response byte 0x01.
3. **CMD8.** Send 48 00 00 01 AA 87 → response bytes 01 00 00 01 AA.
4. **Initialisation loop.** Send CMD55 + ACMD41 (69 40 00 00 00 xx) four times → ACMD41 responses 01, 01, 01, 00. `card_idle` falls in the EXEC of the 4th ACMD41.
5. **Bad CRC.** Send CMD0 with CRC byte 0x41 → R1 0x09 and `crc_err`=1. Then CMD58 after initialisation → 00 C0 FF 80 00.
6. **Illegal commands.**
   - CMD41 without CMD55 → 0x05 (card idle).
   - CMD17 → 0x04 (after initialisation).
   - Assert `rst_n` low during the RESP state → `SD_OUT`=1 on the next `clk`, and the FSM is back in IDLE.
